// File: rtl/mfp_ahb_uart_tx_pkg.sv
// mfp_ahb_uart_tx_pkg: register map, reset divisor and serializer state encoding
package mfp_ahb_uart_tx_pkg;
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;
  localparam logic [15:0] UART_DEFAULT_DIV = 16'd434;
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_t;
endpackage

// File: rtl/mfp_uart_tx_core.sv
// mfp_uart_tx_core: 8N1 serializer with per-frame latched baud divisor
module mfp_uart_tx_core
  import mfp_ahb_uart_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] divisor,
  input  logic [7:0]  data,
  input  logic        valid,
  output logic        pop,
  output logic        tx,
  output logic        busy
);
  tx_state_t state, state_nx;
  logic [15:0] div_q, baud_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shifter;
  logic bit_end;
  assign bit_end = baud_cnt == div_q - 16'd1;
  assign busy = state != ST_IDLE;
  assign tx = state == ST_START ? 1'b0 : state == ST_DATA ? shifter[0] : 1'b1;
  always_comb begin
    state_nx = state;
    pop = 1'b0;
    case (state)
      ST_IDLE: if (valid) begin
        pop = 1'b1;
        state_nx = ST_START;
      end
      ST_START: if (bit_end) state_nx = ST_DATA;
      ST_DATA: if (bit_end && bit_cnt == 3'd7) state_nx = ST_STOP;
      ST_STOP: if (bit_end) begin
        pop = valid;
        state_nx = valid ? ST_START : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end
  // divisor is captured at each pop so mid-frame writes only affect later frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      div_q <= 16'd1;
      baud_cnt <= '0;
      bit_cnt <= '0;
      shifter <= '0;
    end else begin
      state <= state_nx;
      if (pop) begin
        shifter <= data;
        div_q <= divisor == 16'd0 ? 16'd1 : divisor;
        baud_cnt <= '0;
        bit_cnt <= '0;
      end else if (busy) begin
        baud_cnt <= bit_end ? 16'd0 : baud_cnt + 16'd1;
        if (bit_end && state == ST_DATA) begin
          shifter <= shifter >> 1;
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end
endmodule

// File: rtl/mfp_ahb_uart_tx.sv
// mfp_ahb_uart_tx: AHB-Lite slave with TX byte FIFO feeding an 8N1 serializer
module mfp_ahb_uart_tx
  import mfp_ahb_uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = UART_DEFAULT_DIV
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [3:0]  HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        UART_TX,
  output logic        TX_IRQ
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic dp_valid, dp_write;
  logic [1:0] dp_addr;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [15:0] divisor;
  logic overflow, pop, busy, empty, full, wr_en, push, accept;
  logic unused_bits;
  assign unused_bits = ^{HADDR[1:0], HTRANS[0], HWDATA[31:16]};
  assign wr_en = dp_valid & dp_write;
  assign push = wr_en && dp_addr == REG_TXDATA;
  assign empty = count == '0;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign accept = push && (!full || pop);
  assign TX_IRQ = empty & ~busy;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr <= '0;
    end else begin
      dp_valid <= HSEL & HTRANS[1];
      dp_write <= HWRITE;
      dp_addr <= HADDR[3:2];
    end
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      divisor <= DEFAULT_DIV;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(accept) - (AW+1)'(pop);
      if (push && full && !pop) overflow <= 1'b1;
      else if (wr_en && dp_addr == REG_STATUS) overflow <= 1'b0;
      if (wr_en && dp_addr == REG_DIVISOR) divisor <= HWDATA[15:0];
    end
  end
  always_ff @(posedge HCLK) begin
    if (accept) mem[wr_ptr] <= HWDATA[7:0];
  end
  always_comb begin
    HRDATA = dp_addr == REG_STATUS ? {16'h0, 8'(count), 4'h0, overflow, busy, full, empty} :
             dp_addr == REG_DIVISOR ? {16'h0, divisor} : 32'h0;
  end
  mfp_uart_tx_core u_core (
    .clk(HCLK),
    .rst_n(HRESETn),
    .divisor(divisor),
    .data(mem[rd_ptr]),
    .valid(!empty),
    .pop(pop),
    .tx(UART_TX),
    .busy(busy)
  );
endmodule
